regfile_sb: RTL and testbench

- Parametrised successor to the processor's integer register file: N synchronous read ports, one write port and a per-register pending-write scoreboard.
- Write-to-read bypass on the same edge.
- Optional hardwired-zero x0.
- Sits between decode (reads, scoreboard set at issue) and writeback (write, scoreboard clear); the decode stage stalls when a source register is busy.

---
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with N sync read ports, one write port and pending-write scoreboard.
// Latency: reads return 1 cycle after address; same-edge write bypasses into the read.
// Backpressure: none; decode stalls externally on busy_vec / rd_busy.
//
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   rd_en/rd_addr     : per-port read enable and address (port i at [i*AW +: AW])
//   rd_data/rd_busy   : registered read data and scoreboard flag per port (hold when rd_en=0)
//   wr_en/addr/data   : writeback port, also clears the scoreboard bit
//   sb_set/sb_addr    : issue-time scoreboard set
//   busy_vec          : current scoreboard state straight from the flops
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NREAD-1:0]                 rd_en,
  input  logic [NREAD*$clog2(NREGS)-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0]            rd_data,
  output logic [NREAD-1:0]                 rd_busy,
  input  logic                             wr_en,
  input  logic [$clog2(NREGS)-1:0]         wr_addr,
  input  logic [XLEN-1:0]                  wr_data,
  input  logic                             sb_set,
  input  logic [$clog2(NREGS)-1:0]         sb_addr,
  output logic [NREGS-1:0]                 busy_vec
);

  localparam int AW       = $clog2(NREGS);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0]       mem_q [NREGS];
  logic [NREGS-1:0]      busy_q, busy_d;
  logic [NREAD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NREAD-1:0]      rd_busy_q, rd_busy_d;
  logic [AW-1:0]         ra;
  logic                  wr_ok;

  // x0 is never written when hardwired, so its storage stays at the reset value.
  assign wr_ok = wr_en && !(HAS_ZERO && (wr_addr == '0));

  // Clear first, then set: a producer issued in the same cycle the old one
  // retires must leave the register pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)    busy_d[wr_addr] = 1'b0;
    if (sb_set)   busy_d[sb_addr] = 1'b1;
    if (HAS_ZERO) busy_d[0]       = 1'b0;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    ra        = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (rd_en[i]) begin
        if (HAS_ZERO && (ra == '0))
          rd_data_d[i*XLEN +: XLEN] = '0;
        else if (wr_en && (wr_addr == ra))
          rd_data_d[i*XLEN +: XLEN] = wr_data;
        else
          rd_data_d[i*XLEN +: XLEN] = mem_q[ra];
        // Post-edge scoreboard view so a retiring write reads back as not busy.
        rd_busy_d[i] = busy_d[ra];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      if (wr_ok) mem_q[wr_addr] <= wr_data;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_busy  = rd_busy_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed vectors with hand-computed expectations.
// Two instances share stimulus: ZERO_REG=1 (main) and ZERO_REG=0 (x0 writable).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nz;
  logic [1:0]  rd_busy, rd_busy_nz;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [31:0] busy_vec, busy_vec_nz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_vec)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_nz), .rd_busy(rd_busy_nz), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_vec_nz)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset   = 1'b0;
    rd_en   = 2'b00;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    rd_en[p]           = 1'b1;
    rd_addr[p*5 +: 5]  = a;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic set(input logic [4:0] a);
    sb_set  = 1'b1;
    sb_addr = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rd_addr = '0;
    idle();
    #1;

    // Reset, then read x5 / x31
    reset = 1'b1;
    step();
    check("reset_busy_vec", busy_vec, 0);
    check("reset_rd_data",  rd_data,  0);
    idle();
    rd(0, 5'd5); rd(1, 5'd31);
    step();
    check("rst_rd0",     rd_data[31:0],  0);
    check("rst_rd1",     rd_data[63:32], 0);
    check("rst_busy",    rd_busy,        0);
    check("rst_busyvec", busy_vec,       0);

    // Write x3, read the following cycle
    idle(); wr(5'd3, 32'hDEADBEEF);
    step();
    idle(); rd(0, 5'd3);
    step();
    check("wr_rd_data0", rd_data[31:0], 32'hDEADBEEF);
    check("wr_rd_busy0", rd_busy[0],    0);

    // Same-cycle bypass on both ports
    idle(); wr(5'd7, 32'h11);
    step();
    idle(); wr(5'd7, 32'h22); rd(0, 5'd7); rd(1, 5'd7);
    step();
    check("byp_rd0", rd_data[31:0],  32'h22);
    check("byp_rd1", rd_data[63:32], 32'h22);
    idle(); rd(0, 5'd7);
    step();
    check("byp_mem", rd_data[31:0], 32'h22);

    // x0 protection: write + set x0 while reading it
    idle(); wr(5'd0, 32'hFFFFFFFF); set(5'd0); rd(0, 5'd0);
    step();
    check("x0_byp_z",     rd_data[31:0],   0);
    check("x0_busy_z",    busy_vec[0],     0);
    check("x0_byp_nz",    rd_data_nz[31:0], 32'hFFFFFFFF);
    check("x0_rdbusy_nz", rd_busy_nz[0],   1);
    check("x0_busy_nz",   busy_vec_nz[0],  1);
    idle(); rd(0, 5'd0); rd(1, 5'd0);
    step();
    check("x0_mem_z",  rd_data[63:32],    0);
    check("x0_mem_nz", rd_data_nz[63:32], 32'hFFFFFFFF);

    // Scoreboard set / set-wins / clear
    idle(); set(5'd9);
    step();
    check("sb_set9", busy_vec, 32'h0000_0200);
    idle(); rd(1, 5'd9);
    step();
    check("sb_rdbusy9", rd_busy[1], 1);
    idle(); wr(5'd9, 32'h5); set(5'd9); rd(1, 5'd9);
    step();
    check("sb_setwins",   busy_vec[9],     1);
    check("sb_setwins_r", rd_busy[1],      1);
    check("sb_setwins_d", rd_data[63:32],  32'h5);
    idle(); wr(5'd9, 32'h5); rd(0, 5'd9);
    step();
    check("sb_clear",     busy_vec[9],    0);
    check("sb_clear_dat", rd_data[31:0],  32'h5);
    check("sb_clear_bsy", rd_busy[0],     0);

    // Mid-stream reset
    idle(); wr(5'd4, 32'hA5); set(5'd4);
    step();
    idle(); set(5'd12); rd(0, 5'd4);
    step();
    check("pre_rst_busyvec", busy_vec,      32'h0000_1010);
    check("pre_rst_rd0",     rd_data[31:0], 32'hA5);
    check("pre_rst_bsy0",    rd_busy[0],    1);
    idle(); reset = 1'b1; wr(5'd4, 32'h77); set(5'd20); rd(0, 5'd4); rd(1, 5'd4);
    step();
    check("mid_rst_busyvec", busy_vec, 0);
    check("mid_rst_rd",      rd_data,  0);
    check("mid_rst_bsy",     rd_busy,  0);
    idle(); rd(0, 5'd4); rd(1, 5'd12);
    step();
    check("post_rst_x4",  rd_data[31:0],  0);
    check("post_rst_x12", rd_data[63:32], 0);

    // Hold when rd_en[0]=0 while the address (and a would-be bypass) change
    idle(); wr(5'd10, 32'hCAFE);
    step();
    idle(); rd(0, 5'd10);
    step();
    check("hold_init", rd_data[31:0], 32'hCAFE);
    for (int k = 0; k < 3; k++) begin
      idle();
      rd_addr[4:0] = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd10;
      if (k == 1) set(5'd2);
      if (k == 2) wr(5'd10, 32'h1);
      rd(1, 5'd3);
      step();
      check($sformatf("hold_dat%0d", k), rd_data[31:0], 32'hCAFE);
      check($sformatf("hold_bsy%0d", k), rd_busy[0],    0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
